// File: rtl/alu_issue_n.sv
// Issue/writeback stage for alu_n: decodes RV32I integer ALU instructions into
// ALU op/operands (S1), then captures the ALU result into a writeback register (S2).
module alu_issue_n #(
  parameter int unsigned n = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [31:0]  instr_i,
  input  logic [n-1:0] pc_i,
  input  logic [n-1:0] rs1_data_i,
  input  logic [n-1:0] rs2_data_i,
  output logic [n-1:0] operand0_o,
  output logic [n-1:0] operand1_o,
  output logic [3:0]   alu_op_o,
  input  logic [n-1:0] alu_data_i,
  output logic         wb_valid_o,
  input  logic         wb_ready_i,
  output logic [4:0]   wb_rd_o,
  output logic [n-1:0] wb_data_o,
  output logic         illegal_o,
  output logic [31:0]  illegal_instr_o
);

  localparam int unsigned OP_W    = 4;
  localparam int unsigned RD_W    = 5;
  localparam int unsigned INSTR_W = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
  localparam logic [2:0] F3_ADD     = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SR      = 3'b101;

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [RD_W-1:0]   dec_rd;

  logic              dec_legal;
  logic [OP_W-1:0]   dec_op;
  logic [n-1:0]      dec_op0;
  logic [n-1:0]      dec_op1;

  logic              s1_valid;
  logic [RD_W-1:0]   s1_rd;
  logic              s2_free;
  logic              s1_xfer;
  logic              accept;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];
  assign dec_rd = instr_i[11:7];

  // Decode: alu_op is {alt, funct3}; alt selects sub/sra.
  always_comb begin
    dec_legal = 1'b0;
    dec_op    = '0;
    dec_op0   = '0;
    dec_op1   = '0;
    case (opcode)
      OPC_OP: begin
        dec_op0 = rs1_data_i;
        dec_op1 = rs2_data_i;
        if (funct7 == F7_ZERO) begin
          dec_legal = 1'b1;
          dec_op    = {1'b0, funct3};
        end else if (funct7 == F7_ALT && (funct3 == F3_ADD || funct3 == F3_SR)) begin
          dec_legal = 1'b1;
          dec_op    = {1'b1, funct3};
        end
      end
      OPC_OP_IMM: begin
        dec_op0 = rs1_data_i;
        dec_op1 = n'($signed(instr_i[31:20]));
        case (funct3)
          F3_SLL: begin
            dec_op1   = n'(instr_i[24:20]);
            dec_legal = (funct7 == F7_ZERO);
            dec_op    = {1'b0, funct3};
          end
          F3_SR: begin
            dec_op1   = n'(instr_i[24:20]);
            dec_legal = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
            dec_op    = {(funct7 == F7_ALT), funct3};
          end
          default: begin
            dec_legal = 1'b1;
            dec_op    = {1'b0, funct3};
          end
        endcase
      end
      OPC_LUI: begin
        dec_legal = 1'b1;
        dec_op1   = n'($signed({instr_i[31:12], 12'b0}));
      end
      OPC_AUIPC: begin
        dec_legal = 1'b1;
        dec_op0   = pc_i;
        dec_op1   = n'($signed({instr_i[31:12], 12'b0}));
      end
      default: ;
    endcase
  end

  // Handshake: S2 frees when drained; S1 accepts when empty or moving on.
  assign s2_free    = !wb_valid_o || wb_ready_i;
  assign s1_xfer    = s1_valid && s2_free;
  assign in_ready_o = !s1_valid || s2_free;
  assign accept     = in_valid_i && in_ready_o;

  // S1: operands held here drive the ALU directly.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid   <= 1'b0;
      s1_rd      <= '0;
      alu_op_o   <= '0;
      operand0_o <= '0;
      operand1_o <= '0;
    end else if (accept && dec_legal) begin
      s1_valid   <= 1'b1;
      s1_rd      <= dec_rd;
      alu_op_o   <= dec_op;
      operand0_o <= dec_op0;
      operand1_o <= dec_op1;
    end else if (s1_xfer) begin
      s1_valid   <= 1'b0;
    end
  end

  // S2: writeback register; x0 destinations still emit but carry zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wb_valid_o <= 1'b0;
      wb_rd_o    <= '0;
      wb_data_o  <= '0;
    end else if (s1_xfer) begin
      wb_valid_o <= 1'b1;
      wb_rd_o    <= s1_rd;
      wb_data_o  <= (s1_rd == '0) ? '0 : alu_data_i;
    end else if (wb_ready_i) begin
      wb_valid_o <= 1'b0;
    end
  end

  // Illegal report: one pulse per consumed illegal bundle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      illegal_o       <= 1'b0;
      illegal_instr_o <= '0;
    end else begin
      illegal_o <= accept && !dec_legal;
      if (accept && !dec_legal) begin
        illegal_instr_o <= INSTR_W'(instr_i);
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_n.sv
// Bench for alu_issue_n: directed decode checks plus randomized streaming
// against an instruction-level reference model and a behavioural ALU.
module tb_alu_issue_n;

  localparam int unsigned N = 32;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [31:0]  instr_i;
  logic [N-1:0] pc_i, rs1_data_i, rs2_data_i;
  logic [N-1:0] operand0_o, operand1_o;
  logic [3:0]   alu_op_o;
  logic [N-1:0] alu_data;
  logic         wb_valid_o, wb_ready_i;
  logic [4:0]   wb_rd_o;
  logic [N-1:0] wb_data_o;
  logic         illegal_o;
  logic [31:0]  illegal_instr_o;

  alu_issue_n #(.n(N)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .instr_i(instr_i), .pc_i(pc_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .operand0_o(operand0_o), .operand1_o(operand1_o), .alu_op_o(alu_op_o),
    .alu_data_i(alu_data),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
    .illegal_o(illegal_o), .illegal_instr_o(illegal_instr_o)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural alu_n
  always_comb begin
    alu_data = '0;
    case (alu_op_o)
      4'h0: alu_data = operand0_o + operand1_o;
      4'h8: alu_data = operand0_o - operand1_o;
      4'h1: alu_data = operand0_o << operand1_o[4:0];
      4'h2: alu_data = ($signed(operand0_o) < $signed(operand1_o)) ? 32'd1 : 32'd0;
      4'h3: alu_data = (operand0_o < operand1_o) ? 32'd1 : 32'd0;
      4'h4: alu_data = operand0_o ^ operand1_o;
      4'h5: alu_data = operand0_o >> operand1_o[4:0];
      4'hd: alu_data = 32'($signed(operand0_o) >>> operand1_o[4:0]);
      4'h6: alu_data = operand0_o | operand1_o;
      4'h7: alu_data = operand0_o & operand1_o;
      default: alu_data = '0;
    endcase
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%08h exp=%08h @%0t", tag, got, exp, $time);
    end
  endtask

  // RV32I semantics of one ALU-class funct3 operation
  function automatic logic [31:0] sem(input logic [2:0] f3, input bit alt,
                                      input logic [31:0] a, input logic [31:0] x,
                                      input logic [4:0] sh);
    case (f3)
      3'd0: return alt ? a - x : a + x;
      3'd1: return a << sh;
      3'd2: return ($signed(a) < $signed(x)) ? 32'd1 : 32'd0;
      3'd3: return (a < x) ? 32'd1 : 32'd0;
      3'd4: return a ^ x;
      3'd5: return alt ? 32'($signed(a) >>> sh) : a >> sh;
      3'd6: return a | x;
      default: return a & x;
    endcase
  endfunction

  // Reference: legality and architectural result of an instruction
  function automatic void ref_exec(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [31:0] a, input logic [31:0] b,
                                   output bit legal, output logic [31:0] res);
    logic [6:0]  f7 = ins[31:25];
    logic [2:0]  f3 = ins[14:12];
    logic [31:0] imm_i = {{20{ins[31]}}, ins[31:20]};
    logic [31:0] imm_u = {ins[31:12], 12'h000};
    legal = 1'b1;
    res   = '0;
    case (ins[6:0])
      7'h33: begin
        if (f7 == 7'h00) res = sem(f3, 1'b0, a, b, b[4:0]);
        else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) res = sem(f3, 1'b1, a, b, b[4:0]);
        else legal = 1'b0;
      end
      7'h13: begin
        if (f3 == 3'd1 && f7 != 7'h00) legal = 1'b0;
        else if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) legal = 1'b0;
        else res = sem(f3, (f3 == 3'd5) && (f7 == 7'h20), a, imm_i, ins[24:20]);
      end
      7'h37: res = imm_u;
      7'h17: res = pc + imm_u;
      default: legal = 1'b0;
    endcase
    if (ins[11:7] == 5'd0) res = '0;
  endfunction

  function automatic logic [6:0] pick_f7();
    int r = $urandom_range(0, 3);
    if (r < 2) return 7'h00;
    if (r == 2) return 7'h20;
    return 7'($urandom);
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w = $urandom;
    int k = $urandom_range(0, 9);
    if (k <= 2) begin
      w[6:0] = 7'h33; w[31:25] = pick_f7();
    end else if (k <= 5) begin
      w[6:0] = 7'h13;
      if (w[14:12] == 3'd1 || w[14:12] == 3'd5) w[31:25] = pick_f7();
    end else if (k == 6) w[6:0] = 7'h37;
    else if (k == 7) w[6:0] = 7'h17;
    return w;
  endfunction

  typedef struct { logic [4:0] rd; logic [31:0] data; } wb_t;
  wb_t         exp_q[$];
  int          occ;
  bit          exp_ill;
  logic [31:0] exp_ill_word;
  bit          stalled;
  logic [4:0]  snap_rd;
  logic [31:0] snap_data;
  bit          acc_prev;

  task automatic model_clear();
    exp_q.delete();
    occ = 0; exp_ill = 0; stalled = 0; acc_prev = 0;
  endtask

  task automatic run_random(input int cycles, input int rdy_pct, input int vld_pct);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk_i); #1;
      check("illegal_pulse", 32'(illegal_o), 32'(exp_ill));
      if (exp_ill) check("illegal_word", illegal_instr_o, exp_ill_word);
      if (stalled) begin
        check("stall_valid", 32'(wb_valid_o), 32'd1);
        check("stall_rd", 32'(wb_rd_o), 32'(snap_rd));
        check("stall_data", wb_data_o, snap_data);
      end
      if (!in_valid_i || acc_prev) begin
        in_valid_i = ($urandom_range(0, 99) < vld_pct);
        instr_i    = rand_instr();
        pc_i       = $urandom;
        rs1_data_i = $urandom;
        rs2_data_i = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      end
      wb_ready_i = ($urandom_range(0, 99) < rdy_pct);
      @(negedge clk_i);
      check("in_ready", 32'(in_ready_o), 32'(!(occ == 2 && wb_valid_o && !wb_ready_i)));
      stalled = wb_valid_o && !wb_ready_i;
      snap_rd = wb_rd_o;
      snap_data = wb_data_o;
      if (wb_valid_o && wb_ready_i) begin
        if (exp_q.size() == 0) begin
          check("wb_unexpected", 32'(wb_valid_o), 32'd0);
        end else begin
          wb_t e = exp_q.pop_front();
          check("wb_rd", 32'(wb_rd_o), 32'(e.rd));
          check("wb_data", wb_data_o, e.data);
          occ--;
        end
      end
      acc_prev = in_valid_i && in_ready_o;
      exp_ill = 0;
      if (acc_prev) begin
        bit lg; logic [31:0] r;
        ref_exec(instr_i, pc_i, rs1_data_i, rs2_data_i, lg, r);
        if (lg) begin
          exp_q.push_back('{rd: instr_i[11:7], data: r});
          occ++;
        end else begin
          exp_ill = 1; exp_ill_word = instr_i;
        end
      end
    end
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] a, input logic [31:0] b);
    instr_i = ins; pc_i = pc; rs1_data_i = a; rs2_data_i = b; in_valid_i = 1'b1;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
  endtask

  task automatic check_wb(input string tag, input logic [4:0] rd, input logic [31:0] d);
    @(posedge clk_i); #1;
    check({tag, "_valid"}, 32'(wb_valid_o), 32'd1);
    check({tag, "_rd"}, 32'(wb_rd_o), 32'(rd));
    check({tag, "_data"}, wb_data_o, d);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready_o), 32'd1);
    check({tag, "_wb_valid"}, 32'(wb_valid_o), 32'd0);
    check({tag, "_wb_rd"}, 32'(wb_rd_o), 32'd0);
    check({tag, "_wb_data"}, wb_data_o, 32'd0);
    check({tag, "_op0"}, operand0_o, 32'd0);
    check({tag, "_op1"}, operand1_o, 32'd0);
    check({tag, "_alu_op"}, 32'(alu_op_o), 32'd0);
    check({tag, "_illegal"}, 32'(illegal_o), 32'd0);
    check({tag, "_illegal_word"}, illegal_instr_o, 32'd0);
  endtask

  initial begin
    rst_ni = 1'b0; in_valid_i = 1'b0; wb_ready_i = 1'b1;
    instr_i = '0; pc_i = '0; rs1_data_i = '0; rs2_data_i = '0;
    model_clear();
    repeat (3) @(posedge clk_i);
    #1 check_all_zero("reset");
    @(negedge clk_i); rst_ni = 1'b1;

    // Directed decode and writeback
    issue(32'h002081B3, 0, 5, 7);
    check("add_op", 32'(alu_op_o), 32'h0);
    check("add_op0", operand0_o, 32'd5);
    check("add_op1", operand1_o, 32'd7);
    check_wb("add", 5'd3, 32'd12);

    issue(32'h402081B3, 0, 5, 7);
    check("sub_op", 32'(alu_op_o), 32'h8);
    check_wb("sub", 5'd3, 32'hFFFFFFFE);

    issue(32'h40335293, 0, 32'h80000000, 0);
    check("srai_op", 32'(alu_op_o), 32'hd);
    check("srai_op1", operand1_o, 32'd3);
    check_wb("srai", 5'd5, 32'hF0000000);

    issue(32'h123450B7, 0, 32'hDEADBEEF, 32'h1);
    check("lui_op0", operand0_o, 32'd0);
    check("lui_op1", operand1_o, 32'h12345000);
    check_wb("lui", 5'd1, 32'h12345000);

    issue(32'h00001097, 32'h100, 0, 0);
    check("auipc_op0", operand0_o, 32'h100);
    check_wb("auipc", 5'd1, 32'h1100);

    // Back-to-back illegal words
    instr_i = 32'h00000000; in_valid_i = 1'b1;
    @(posedge clk_i); #1;
    check("ill0_pulse", 32'(illegal_o), 32'd1);
    check("ill0_word", illegal_instr_o, 32'h00000000);
    instr_i = 32'h40009093;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    check("ill1_pulse", 32'(illegal_o), 32'd1);
    check("ill1_word", illegal_instr_o, 32'h40009093);
    check("ill1_no_wb", 32'(wb_valid_o), 32'd0);
    @(posedge clk_i); #1;
    check("ill_end_pulse", 32'(illegal_o), 32'd0);
    check("ill_end_no_wb", 32'(wb_valid_o), 32'd0);

    issue(32'h00208033, 0, 5, 7);
    check_wb("add_x0", 5'd0, 32'd0);
    @(posedge clk_i); #1;
    check("drained", 32'(wb_valid_o), 32'd0);

    // Randomized streaming with varying backpressure
    model_clear();
    run_random(400, 70, 80);
    run_random(300, 25, 95);
    run_random(300, 100, 100);
    run_random(12, 100, 0);
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    // Fill both stages, then reset asynchronously mid-cycle
    wb_ready_i = 1'b0;
    instr_i = 32'h002081B3; rs1_data_i = 1; rs2_data_i = 2; in_valid_i = 1'b1;
    repeat (4) @(posedge clk_i);
    #1 in_valid_i = 1'b0;
    check("full_wb_valid", 32'(wb_valid_o), 32'd1);
    check("full_in_ready", 32'(in_ready_o), 32'd0);
    #2 rst_ni = 1'b0;
    #1 check_all_zero("async_rst");
    @(negedge clk_i); rst_ni = 1'b1; wb_ready_i = 1'b1;
    @(posedge clk_i); #1;
    check("post_rst_in_ready", 32'(in_ready_o), 32'd1);
    check("post_rst_wb_valid", 32'(wb_valid_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
